act_buf_pingpong_ctrl: RTL and testbench
========================================

Name: act_buf_pingpong_ctrl

Overview:
- Scheduler for a double-buffered activation BRAM shared between the activation writer (producer) and the PE (consumer) of a conv layer.
- Replaces the single-buffer SyncSig vld/ack pairing, so the writer fills one bank while the PE drains the other.
- Owns the per-bank state, issues grants to each side, and forms full BRAM addresses as {bank, local address}.
- Counts drained tiles and flags the end of each frame.

Parameters:
AWIDTH, 10, local (per-bank) address width; the BRAM address is AWIDTH+1 bits
TILES_PER_FRAME, 4, tiles per frame; legal range 1..65535
CNT_W, 16, tile counter width

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
wr_req  in  1  writer requests a bank to fill (level)
wr_gnt  out  1  writer owns wr_bank (registered level)
wr_bank  out  1  bank granted to the writer
wr_done  in  1  single-cycle pulse: writer finished its bank
wr_addr_local  in  AWIDTH  writer local address
wr_addr  out  AWIDTH+1  {wr_bank, wr_addr_local}; combinational
rd_req  in  1  PE requests a filled bank (level)
rd_gnt  out  1  PE owns rd_bank (registered level)
rd_bank  out  1  bank granted to the PE
rd_done  in  1  single-cycle pulse: PE finished its bank
rd_addr_local  in  AWIDTH  PE local address
rd_addr  out  AWIDTH+1  {rd_bank, rd_addr_local}; combinational
full_cnt  out  2  number of banks in the FULL state
tile_idx  out  CNT_W  index of the tile currently held or next granted to the PE
frame_done  out  1  one-cycle pulse on the last tile's rd_done
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Per-bank state, 2 bits each: EMPTY, FILLING, FULL, DRAINING. Bank states are independent of each other.
- wr_ptr and rd_ptr are 1-bit pointers that toggle in order, so banks are filled and drained strictly alternately (0, 1, 0, ...).
- Reset (ap_rst=1 at a clock edge): both banks EMPTY; wr_ptr=rd_ptr=0; wr_gnt=rd_gnt=0; wr_bank=rd_bank=0; full_cnt=0; tile_idx=0; frame_done=0; proto_err=0.
  - Reset mid-operation discards all bank contents and ownership immediately. There is no drain.
- Write grant:
  - Condition: wr_req && !wr_gnt && state[wr_ptr]==EMPTY.
  - Next cycle: wr_gnt=1, wr_bank=wr_ptr, state[wr_ptr]=FILLING.
  - Minimum request-to-grant latency is 1 cycle. wr_gnt holds until release.
- Write release:
  - Condition: wr_done && wr_gnt.
  - Next cycle: state[wr_bank]=FULL, wr_gnt=0, wr_ptr toggles.
  - A new grant needs wr_req sampled again with wr_gnt=0, so back-to-back ownership has at least one idle cycle.
- Read grant:
  - Condition: rd_req && !rd_gnt && state[rd_ptr]==FULL.
  - Next cycle: rd_gnt=1, rd_bank=rd_ptr, state[rd_ptr]=DRAINING.
- Read release:
  - Condition: rd_done && rd_gnt.
  - Next cycle: state[rd_bank]=EMPTY, rd_gnt=0, rd_ptr toggles.
  - tile_idx increments. If tile_idx==TILES_PER_FRAME-1, tile_idx wraps to 0 and frame_done pulses for one cycle, coincident with rd_gnt falling.
- No bypass: a state change becomes visible to the other side one cycle after it is registered.
  - wr_done on bank B in cycle t with rd_req pending for B: rd_gnt rises at t+2.
  - rd_done on B in cycle t with wr_req pending for B: wr_gnt rises at t+2.
- Write and read events on different banks in the same cycle are processed independently, with no priority.
- full_cnt is registered and recomputed from the next-state bank vector, range 0..2. Both banks FULL while the PE is idle is legal; wr_req then stalls with no grant.
- proto_err is set, and stays set until reset, on any of:
  - wr_done while !wr_gnt;
  - rd_done while !rd_gnt;
  - wr_req dropped while waiting? No: dropping wr_req before grant is legal and simply cancels the request.
  - Offending done pulses cause no state change.
- Address muxing is pure combinational concatenation, with the bank bit as MSB. When not granted, the outputs still reflect the stale bank bit. The BRAM ce/we are gated by the requester, not by this block.

Test Plan:
- Reset then wr_req=1 held: wr_gnt=1, wr_bank=0 one cycle after first sample. wr_done at cycle 10 → wr_gnt=0 and full_cnt=1 at cycle 11. With rd_req=1, rd_gnt=1, rd_bank=0 at cycle 12.
- Overlap: writer fills bank1 while PE drains bank0. With wr_addr_local=0x005, wr_addr=0x405; simultaneously rd_addr_local=0x3FF gives rd_addr=0x3FF. Both grants are held concurrently.
- Back-pressure: PE idle while writer fills banks 0 and 1 → full_cnt=2; third wr_req gets no wr_gnt. One rd_done then produces wr_gnt (bank0) two cycles after rd_done.
- Frame count with TILES_PER_FRAME=4: four complete write/read pairs give tile_idx 0→1→2→3→0, and frame_done pulses exactly once, on the 4th release.
- Protocol error: wr_done with wr_gnt=0 → proto_err=1 next cycle; bank states and full_cnt unchanged; flag persists until ap_rst.
- Reset mid-operation: ap_rst asserted while rd_gnt=1 and full_cnt=1 → next cycle all outputs are at reset values, and the next grant goes to bank 0.

Source files
------------

// File: rtl/act_buf_pingpong_if.sv
// ---------------------------------------------------------------------------
// act_buf_if
//
// Handshake and address bundle between the ping-pong activation buffer
// scheduler and its two clients: the activation writer and the PE.
//
// Signal summary (direction as seen by the scheduler, modport "slave"):
//   wr_req         in   writer requests a bank to fill (level)
//   wr_gnt         out  writer owns wr_bank (registered level)
//   wr_bank        out  bank granted to the writer
//   wr_done        in   one-cycle pulse, writer finished its bank
//   wr_addr_local  in   writer local (per-bank) address
//   wr_addr        out  {wr_bank, wr_addr_local}
//   rd_req         in   PE requests a filled bank (level)
//   rd_gnt         out  PE owns rd_bank (registered level)
//   rd_bank        out  bank granted to the PE
//   rd_done        in   one-cycle pulse, PE finished its bank
//   rd_addr_local  in   PE local (per-bank) address
//   rd_addr        out  {rd_bank, rd_addr_local}
//   full_cnt       out  number of banks currently FULL
//   tile_idx       out  tile held by, or next granted to, the PE
//   frame_done     out  one-cycle pulse on the last tile's release
//   proto_err      out  sticky protocol-violation flag
//
// The "master" modport is the client view (writer + PE combined).
// ---------------------------------------------------------------------------
interface act_buf_if #(
  parameter int AWIDTH = 10,
  parameter int CNT_W  = 16
);

  // Writer side
  logic              wr_req;
  logic              wr_gnt;
  logic              wr_bank;
  logic              wr_done;
  logic [AWIDTH-1:0] wr_addr_local;
  logic [AWIDTH:0]   wr_addr;

  // PE side
  logic              rd_req;
  logic              rd_gnt;
  logic              rd_bank;
  logic              rd_done;
  logic [AWIDTH-1:0] rd_addr_local;
  logic [AWIDTH:0]   rd_addr;

  // Status
  logic [1:0]        full_cnt;
  logic [CNT_W-1:0]  tile_idx;
  logic              frame_done;
  logic              proto_err;

  modport master (
    output wr_req, wr_done, wr_addr_local,
    output rd_req, rd_done, rd_addr_local,
    input  wr_gnt, wr_bank, wr_addr,
    input  rd_gnt, rd_bank, rd_addr,
    input  full_cnt, tile_idx, frame_done, proto_err
  );

  modport slave (
    input  wr_req, wr_done, wr_addr_local,
    input  rd_req, rd_done, rd_addr_local,
    output wr_gnt, wr_bank, wr_addr,
    output rd_gnt, rd_bank, rd_addr,
    output full_cnt, tile_idx, frame_done, proto_err
  );

endinterface

// File: rtl/act_buf_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// act_buf_pingpong_ctrl
//
// Scheduler for a double-buffered activation BRAM shared by the activation
// writer (producer) and the PE (consumer) of a conv layer. The writer fills
// one bank while the PE drains the other. Each bank walks
// EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY; the two banks are filled
// and drained strictly alternately (0, 1, 0, ...).
//
// Ports:
//   ap_clk   in  clock
//   ap_rst   in  synchronous active-high reset
//   bus      act_buf_if.slave -- writer/PE handshakes, local addresses in,
//            full BRAM addresses out, tile/frame counters and error flag.
//
// Parameters:
//   AWIDTH           local (per-bank) address width; BRAM address is AWIDTH+1
//   TILES_PER_FRAME  tiles per frame, 1..65535
//   CNT_W            tile counter width
// ---------------------------------------------------------------------------
module act_buf_pingpong_ctrl #(
  parameter int AWIDTH          = 10,
  parameter int TILES_PER_FRAME = 4,
  parameter int CNT_W           = 16
) (
  input  logic     ap_clk,
  input  logic     ap_rst,
  act_buf_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(TILES_PER_FRAME - 1);

  // Registered state
  bank_state_e      bank_st [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             wr_gnt_q;
  logic             wr_bank_q;
  logic             rd_gnt_q;
  logic             rd_bank_q;
  logic [1:0]       full_cnt_q;
  logic [CNT_W-1:0] tile_idx_q;
  logic             frame_done_q;
  logic             proto_err_q;

  // Next-state values
  bank_state_e      bank_st_nxt [2];
  logic             wr_ptr_nxt;
  logic             rd_ptr_nxt;
  logic             wr_gnt_nxt;
  logic             wr_bank_nxt;
  logic             rd_gnt_nxt;
  logic             rd_bank_nxt;
  logic [1:0]       full_cnt_nxt;
  logic [CNT_W-1:0] tile_idx_nxt;
  logic             frame_done_nxt;
  logic             proto_err_nxt;

  // Handshake events, all decoded from registered state only (no bypass:
  // a release on one side becomes visible to the other side a cycle later).
  logic wr_grant_ev;
  logic wr_release_ev;
  logic rd_grant_ev;
  logic rd_release_ev;
  logic wr_stray_done;
  logic rd_stray_done;

  // Number of banks in FULL within a two-bank state vector.
  function automatic logic [1:0] count_full(input bank_state_e b0,
                                            input bank_state_e b1);
    logic [1:0] n;
    n = 2'd0;
    if (b0 == FULL) n = n + 2'd1;
    if (b1 == FULL) n = n + 2'd1;
    return n;
  endfunction

  // Tile counter advance with wrap at the end of the frame.
  function automatic logic [CNT_W-1:0] next_tile(input logic [CNT_W-1:0] idx);
    if (idx == LAST_TILE) return '0;
    return idx + CNT_W'(1);
  endfunction

  assign wr_grant_ev   = bus.wr_req && !wr_gnt_q && (bank_st[wr_ptr] == EMPTY);
  assign wr_release_ev = bus.wr_done && wr_gnt_q;
  assign rd_grant_ev   = bus.rd_req && !rd_gnt_q && (bank_st[rd_ptr] == FULL);
  assign rd_release_ev = bus.rd_done && rd_gnt_q;
  assign wr_stray_done = bus.wr_done && !wr_gnt_q;
  assign rd_stray_done = bus.rd_done && !rd_gnt_q;

  // Next-state logic. The four events always touch different banks (the
  // writer only grabs EMPTY, releases FILLING; the PE only grabs FULL,
  // releases DRAINING), so they can be applied in any order without conflict.
  always_comb begin
    bank_st_nxt[0] = bank_st[0];
    bank_st_nxt[1] = bank_st[1];
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    wr_gnt_nxt     = wr_gnt_q;
    wr_bank_nxt    = wr_bank_q;
    rd_gnt_nxt     = rd_gnt_q;
    rd_bank_nxt    = rd_bank_q;
    tile_idx_nxt   = tile_idx_q;
    frame_done_nxt = 1'b0;
    proto_err_nxt  = proto_err_q | wr_stray_done | rd_stray_done;

    if (wr_grant_ev) begin
      wr_gnt_nxt          = 1'b1;
      wr_bank_nxt         = wr_ptr;
      bank_st_nxt[wr_ptr] = FILLING;
    end

    if (wr_release_ev) begin
      bank_st_nxt[wr_bank_q] = FULL;
      wr_gnt_nxt             = 1'b0;
      wr_ptr_nxt             = ~wr_ptr;
    end

    if (rd_grant_ev) begin
      rd_gnt_nxt          = 1'b1;
      rd_bank_nxt         = rd_ptr;
      bank_st_nxt[rd_ptr] = DRAINING;
    end

    if (rd_release_ev) begin
      bank_st_nxt[rd_bank_q] = EMPTY;
      rd_gnt_nxt             = 1'b0;
      rd_ptr_nxt             = ~rd_ptr;
      tile_idx_nxt           = next_tile(tile_idx_q);
      frame_done_nxt         = (tile_idx_q == LAST_TILE);
    end

    full_cnt_nxt = count_full(bank_st_nxt[0], bank_st_nxt[1]);
  end

  // State register. Reset drops all ownership and bank contents at once.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      bank_st[0]   <= EMPTY;
      bank_st[1]   <= EMPTY;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_gnt_q     <= 1'b0;
      wr_bank_q    <= 1'b0;
      rd_gnt_q     <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_cnt_q   <= 2'd0;
      tile_idx_q   <= '0;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      bank_st[0]   <= bank_st_nxt[0];
      bank_st[1]   <= bank_st_nxt[1];
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      wr_gnt_q     <= wr_gnt_nxt;
      wr_bank_q    <= wr_bank_nxt;
      rd_gnt_q     <= rd_gnt_nxt;
      rd_bank_q    <= rd_bank_nxt;
      full_cnt_q   <= full_cnt_nxt;
      tile_idx_q   <= tile_idx_nxt;
      frame_done_q <= frame_done_nxt;
      proto_err_q  <= proto_err_nxt;
    end
  end

  // Outputs. Addresses keep the last granted bank bit even when idle; the
  // clients gate the BRAM enables themselves.
  assign bus.wr_gnt     = wr_gnt_q;
  assign bus.wr_bank    = wr_bank_q;
  assign bus.wr_addr    = {wr_bank_q, bus.wr_addr_local};
  assign bus.rd_gnt     = rd_gnt_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.rd_addr    = {rd_bank_q, bus.rd_addr_local};
  assign bus.full_cnt   = full_cnt_q;
  assign bus.tile_idx   = tile_idx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_act_buf_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for act_buf_pingpong_ctrl. Directed steps follow the ping-pong
// scenarios, then a randomized phase; every cycle all outputs are compared
// against a transaction-level model (owner of each side, FIFO of filled
// banks, count of drained tiles).
// ---------------------------------------------------------------------------
module tb_act_buf_pingpong_ctrl;

  localparam int AW  = 10;
  localparam int TPF = 4;
  localparam int CW  = 16;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;

  act_buf_if #(.AWIDTH(AW), .CNT_W(CW)) bus ();

  act_buf_pingpong_ctrl #(
    .AWIDTH(AW),
    .TILES_PER_FRAME(TPF),
    .CNT_W(CW)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus.slave)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: who owns what, which filled banks wait for the PE
  int w_own, r_own;        // bank owned by writer / PE, -1 if none
  int w_next, r_next;      // bank the next grant goes to
  int w_bank_m, r_bank_m;  // last granted bank
  int ready_q[$];          // filled banks, oldest first
  int drained;             // tiles released by the PE since reset
  bit frame_m, perr_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit bank_free(input int b);
    foreach (ready_q[i]) if (ready_q[i] == b) return 1'b0;
    return (w_own != b) && (r_own != b);
  endfunction

  task automatic model_reset();
    w_own = -1; r_own = -1; w_next = 0; r_next = 0;
    w_bank_m = 0; r_bank_m = 0; ready_q.delete();
    drained = 0; frame_m = 1'b0; perr_m = 1'b0;
  endtask

  // Evaluate one clock edge of the model with the inputs currently driven.
  task automatic model_step();
    bit wg, wrl, rg, rrl;
    if (ap_rst) begin
      model_reset();
      return;
    end
    wg  = bus.wr_req && (w_own < 0) && bank_free(w_next);
    wrl = bus.wr_done && (w_own >= 0);
    rg  = bus.rd_req && (r_own < 0) && (ready_q.size() > 0) && (ready_q[0] == r_next);
    rrl = bus.rd_done && (r_own >= 0);
    if (bus.wr_done && w_own < 0) perr_m = 1'b1;
    if (bus.rd_done && r_own < 0) perr_m = 1'b1;
    frame_m = 1'b0;
    if (rg) begin
      r_own = ready_q.pop_front();
      r_bank_m = r_own;
    end
    if (rrl) begin
      drained++;
      r_own = -1;
      r_next ^= 1;
      if (drained % TPF == 0) frame_m = 1'b1;
    end
    if (wg) begin
      w_own = w_next;
      w_bank_m = w_next;
    end
    if (wrl) begin
      ready_q.push_back(w_own);
      w_own = -1;
      w_next ^= 1;
    end
  endtask

  task automatic check_all();
    chk("wr_gnt",     32'(bus.wr_gnt),     32'(w_own >= 0));
    chk("wr_bank",    32'(bus.wr_bank),    32'(w_bank_m));
    chk("rd_gnt",     32'(bus.rd_gnt),     32'(r_own >= 0));
    chk("rd_bank",    32'(bus.rd_bank),    32'(r_bank_m));
    chk("full_cnt",   32'(bus.full_cnt),   32'(ready_q.size()));
    chk("tile_idx",   32'(bus.tile_idx),   32'(drained % TPF));
    chk("frame_done", 32'(bus.frame_done), 32'(frame_m));
    chk("proto_err",  32'(bus.proto_err),  32'(perr_m));
    chk("wr_addr",    32'(bus.wr_addr),    (32'(w_bank_m) << AW) | 32'(bus.wr_addr_local));
    chk("rd_addr",    32'(bus.rd_addr),    (32'(r_bank_m) << AW) | 32'(bus.rd_addr_local));
  endtask

  task automatic cycle();
    model_step();
    @(posedge ap_clk);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    bus.wr_req = 1'b0; bus.wr_done = 1'b0; bus.wr_addr_local = '0;
    bus.rd_req = 1'b0; bus.rd_done = 1'b0; bus.rd_addr_local = '0;

    // Reset
    ap_rst = 1'b1;
    cycle();
    cycle();
    chk("rst_full_cnt", 32'(bus.full_cnt), 32'd0);
    chk("rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
    ap_rst = 1'b0;

    // Basic fill then drain of bank 0
    bus.wr_req = 1'b1;
    cycle();
    chk("t1_wr_gnt_lat", 32'(bus.wr_gnt), 32'd1);
    chk("t1_wr_bank", 32'(bus.wr_bank), 32'd0);
    repeat (8) cycle();
    bus.wr_done = 1'b1;
    cycle();
    bus.wr_done = 1'b0;
    bus.wr_req  = 1'b0;
    chk("t1_wr_gnt_fall", 32'(bus.wr_gnt), 32'd0);
    chk("t1_full_cnt", 32'(bus.full_cnt), 32'd1);
    bus.rd_req = 1'b1;
    cycle();
    chk("t1_rd_gnt", 32'(bus.rd_gnt), 32'd1);
    chk("t1_rd_bank", 32'(bus.rd_bank), 32'd0);

    // Overlap: writer fills bank 1 while PE drains bank 0
    bus.wr_req = 1'b1;
    cycle();
    bus.wr_addr_local = 10'h005;
    bus.rd_addr_local = 10'h3FF;
    #1;
    chk("ovl_wr_addr", 32'(bus.wr_addr), 32'h405);
    chk("ovl_rd_addr", 32'(bus.rd_addr), 32'h3FF);
    chk("ovl_both_gnt", {30'd0, bus.wr_gnt, bus.rd_gnt}, 32'd3);
    cycle();
    bus.rd_done = 1'b1;
    cycle();
    bus.rd_done = 1'b0;
    bus.wr_req  = 1'b0;
    bus.wr_done = 1'b1;
    cycle();
    bus.wr_done = 1'b0;
    cycle();
    cycle();
    chk("ovl_rd_bank1", 32'(bus.rd_bank), 32'd1);
    bus.rd_done = 1'b1;
    cycle();
    bus.rd_done = 1'b0;
    bus.rd_req  = 1'b0;

    // Back-pressure: both banks fill with the PE idle
    bus.wr_req = 1'b1;
    cycle();
    bus.wr_done = 1'b1;
    cycle();
    bus.wr_done = 1'b0;
    cycle();
    cycle();
    bus.wr_done = 1'b1;
    cycle();
    bus.wr_done = 1'b0;
    repeat (3) cycle();
    chk("bp_full_cnt", 32'(bus.full_cnt), 32'd2);
    chk("bp_no_gnt", 32'(bus.wr_gnt), 32'd0);
    bus.rd_req = 1'b1;
    cycle();
    bus.rd_done = 1'b1;
    cycle();
    bus.rd_done = 1'b0;
    chk("bp_gnt_t1", 32'(bus.wr_gnt), 32'd0);
    cycle();
    chk("bp_gnt_t2", 32'(bus.wr_gnt), 32'd1);
    chk("bp_gnt_bank", 32'(bus.wr_bank), 32'd0);
    chk("bp_tile", 32'(bus.tile_idx), 32'd3);

    // Fourth tile of the frame: wrap and frame pulse
    bus.rd_done = 1'b1;
    cycle();
    bus.rd_done = 1'b0;
    bus.rd_req  = 1'b0;
    chk("frm_tile_wrap", 32'(bus.tile_idx), 32'd0);
    chk("frm_done_pulse", 32'(bus.frame_done), 32'd1);
    bus.wr_done = 1'b1;
    cycle();
    bus.wr_done = 1'b0;
    bus.wr_req  = 1'b0;
    chk("frm_done_clear", 32'(bus.frame_done), 32'd0);

    // Protocol error: stray wr_done
    bus.wr_done = 1'b1;
    cycle();
    bus.wr_done = 1'b0;
    chk("perr_set", 32'(bus.proto_err), 32'd1);
    chk("perr_full_cnt", 32'(bus.full_cnt), 32'd1);
    repeat (3) cycle();
    chk("perr_sticky", 32'(bus.proto_err), 32'd1);

    // Reset while the PE holds a bank and one bank is FULL
    bus.wr_req = 1'b1;
    cycle();
    cycle();
    bus.wr_done = 1'b1;
    cycle();
    bus.wr_done = 1'b0;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b1;
    cycle();
    chk("mid_rd_gnt", 32'(bus.rd_gnt), 32'd1);
    chk("mid_full_cnt", 32'(bus.full_cnt), 32'd1);
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    chk("mid_rst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
    chk("mid_rst_perr", 32'(bus.proto_err), 32'd0);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b1;
    cycle();
    chk("mid_next_bank", 32'(bus.wr_bank), 32'd0);
    chk("mid_next_gnt", 32'(bus.wr_gnt), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.wr_req        = ($urandom_range(0, 3) != 0);
      bus.rd_req        = ($urandom_range(0, 3) != 0);
      bus.wr_done       = ((w_own >= 0) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0);
      bus.rd_done       = ((r_own >= 0) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0);
      bus.wr_addr_local = AW'($urandom);
      bus.rd_addr_local = AW'($urandom);
      ap_rst            = (i == 700) || (i == 701);
      cycle();
    end
    ap_rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
